uop_cracker: RTL and testbench
==============================

# uop_cracker

Upstream feeder for the eZ90 uop FIFO. The cracker accepts one decoded macro-op per handshake. Each macro-op carries up to MAX_UOPS packed uop slots. The cracker emits the slots one at a time on a ready/valid output that drives the FIFO's push side. Each emitted uop is tagged with its sequence index, first/last flags and the parent PC, so later stages can rebuild macro-op boundaries.

## Interface
Parameters:
- MAX_UOPS, default 4: maximum uops per macro-op; must be ≥1.
- UOP_W, default 32: width of one uop slot.
- PC_W, default 16: width of the macro-op PC.

Ports:
- clk  in  1  core clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  macro-op offered.
- in_ready  out  1  cracker can accept a macro-op.
- in_count  in  CNT_W = $clog2(MAX_UOPS+1)  number of valid slots.
- in_uops  in  MAX_UOPS×UOP_W  packed slots; slot 0 is in the LSBs.
- in_pc  in  PC_W  macro-op PC.
- out_valid  out  1  uop valid.
- out_ready  in  1  downstream FIFO ready (its in_ready).
- out_uop  out  UOP_W  current uop.
- out_idx  out  IDX_W = max(1,$clog2(MAX_UOPS))  slot index.
- out_first  out  1  out_idx == 0.
- out_last  out  1  out_idx == held count − 1.
- out_pc  out  PC_W  parent PC.
- err_illegal  out  1  one-cycle pulse: a macro-op with an illegal count was accepted.

## Operation
- States:
  - IDLE: no macro-op held.
  - EMIT: a macro-op is held in registers.
- Handshakes: in_fire = in_valid && in_ready; out_fire = out_valid && out_ready.
- in_ready = !flush && (IDLE || (out_fire && out_last)).
- out_valid = EMIT. out_uop is the held slot at idx_q.
- IDLE, in_fire with 1 ≤ in_count ≤ MAX_UOPS: capture uops, pc and count; set idx_q = 0; go to EMIT.
- IDLE, in_fire with in_count == 0 or in_count > MAX_UOPS: consume the macro-op, emit nothing, pulse err_illegal next cycle, stay in IDLE.
- EMIT, out_fire with !out_last: idx_q += 1.
- EMIT, out_fire with out_last:
  - with a legal in_fire: load the new macro-op, set idx_q = 0, stay in EMIT (zero-bubble).
  - otherwise (no in_fire, or an illegal in_fire, which pulses err_illegal): go to IDLE.
- EMIT, no out_fire: all outputs held stable, no state change.
- flush: next state is IDLE, idx_q = 0, held data discarded. It overrides in_fire and out_fire in the same cycle; in_ready is forced low so nothing is lost silently. An uop whose out_fire coincides with flush still counts as delivered downstream.
- idx_q never exceeds count − 1. No wrap-around arithmetic is needed.

## Timing
- Reset values: state IDLE; idx_q 0; held registers 0; out_valid 0; out_uop/out_idx/out_pc 0; out_first 1; out_last 0; err_illegal 0. in_ready resets to 1 (0 while flush is high).
- Latency: in_fire at cycle N gives out_valid with idx 0 at cycle N+1.
- Throughput: one uop per cycle. Back-to-back macro-ops have no bubble.
- All outputs except in_ready come from registers or a mux of registered data; no combinational path from in_* to out_*.
- in_ready depends combinationally on out_ready. The downstream FIFO's in_ready is registered, so no loop forms.
- Reset asserted mid-EMIT drops the held macro-op immediately.

## Configuration
- EZ90_UOP_CRACKER_PERF_EN defined: adds 32-bit output ports perf_macros (increments on each legal in_fire) and perf_uops (increments on each out_fire). Both reset to 0, clear on flush, and wrap modulo 2^32.
- Not defined: neither the ports nor the counters exist.

## Structure
- Shared package ez90_uop_pkg: crack_state_e (IDLE, EMIT), the CNT_W/IDX_W helper functions, and a uop_tag_t struct {idx, first, last, pc}.
- One sub-module is natural: uop_cracker_perf, holding the counters, instantiated only under the macro.
- Everything else is a single always_ff plus combinational next-state logic.

## Test plan
- Single-uop macro: in_count=1, uops[0]=0xA5A5_0001, pc=0x1234, out_ready=1 → cycle+1: out_valid, idx 0, first=1, last=1, out_pc 0x1234; in_ready=1 the same cycle.
- Three-uop macro with backpressure: in_count=3; out_ready pattern 1,0,1,1 → uops emitted at idx 0,1(held 2 cycles, stable),2; last=1 only on idx 2.
- Back-to-back: two 2-uop macros offered continuously with out_ready=1 → four consecutive out_fire cycles, no bubble; second macro's first=1 on the cycle after the first macro's last.
- Illegal count: in_count=0, then in_count=5 with MAX_UOPS=4 → both accepted, no out_valid, err_illegal pulses once for each.
- Flush mid-EMIT: 4-uop macro; flush asserted after idx 1 fires → next cycle out_valid=0, in_ready=1. A subsequent macro starts at idx 0.
- Async reset while out_valid=1 at idx 2 → out_valid drops without waiting for a clock. After release: in_ready=1, perf counters 0 when PERF_EN is defined.

Source files
------------

// File: rtl/ez90_uop_pkg.sv
// Shared types and width helpers for the eZ90 uop cracker.
// Used by uop_cracker and uop_cracker_perf.
package ez90_uop_pkg;

  typedef enum logic {
    IDLE,
    EMIT
  } crack_state_e;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Tag layout for later stages; sized for the widest configuration.
  localparam int TAG_IDX_W = 8;
  localparam int TAG_PC_W  = 64;

  typedef struct packed {
    logic [TAG_IDX_W-1:0] idx;
    logic                 first;
    logic                 last;
    logic [TAG_PC_W-1:0]  pc;
  } uop_tag_t;

endpackage

// File: rtl/uop_cracker_perf.sv
// Macro-op and uop event counters for the uop cracker.
// Built only when EZ90_UOP_CRACKER_PERF_EN is defined.
module uop_cracker_perf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        inc_macro,
  input  logic        inc_uop,
  output logic [31:0] perf_macros,
  output logic [31:0] perf_uops
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_macros <= '0;
      perf_uops   <= '0;
    end else if (flush) begin
      perf_macros <= '0;
      perf_uops   <= '0;
    end else begin
      if (inc_macro) perf_macros <= perf_macros + 32'd1;
      if (inc_uop)   perf_uops   <= perf_uops + 32'd1;
    end
  end

endmodule

// File: rtl/uop_cracker.sv
// Cracks a macro-op into tagged uops, one per cycle.
// Optional counters under EZ90_UOP_CRACKER_PERF_EN.
module uop_cracker
  import ez90_uop_pkg::*;
#(
  parameter  int MAX_UOPS = 4,
  parameter  int UOP_W    = 32,
  parameter  int PC_W     = 16,
  localparam int CNT_W    = cnt_w(MAX_UOPS),
  localparam int IDX_W    = idx_w(MAX_UOPS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CNT_W-1:0]          in_count,
  input  logic [MAX_UOPS*UOP_W-1:0] in_uops,
  input  logic [PC_W-1:0]           in_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [UOP_W-1:0]          out_uop,
  output logic [IDX_W-1:0]          out_idx,
  output logic                      out_first,
  output logic                      out_last,
  output logic [PC_W-1:0]           out_pc,
  output logic                      err_illegal
`ifdef EZ90_UOP_CRACKER_PERF_EN
  ,
  output logic [31:0]               perf_macros,
  output logic [31:0]               perf_uops
`endif
);

  crack_state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q;
  logic [MAX_UOPS-1:0][UOP_W-1:0] uops_q;
  logic [PC_W-1:0] pc_q;
  logic err_q;

  logic [CNT_W-1:0] idx_ext;
  logic last;
  logic legal;
  logic in_fire;
  logic out_fire;
  logic load;

  assign idx_ext = CNT_W'(idx_q);
  assign last    = (idx_ext + CNT_W'(1)) == cnt_q;
  assign legal   = (in_count != '0) &&
                   (in_count <= CNT_W'(MAX_UOPS));

  assign out_valid = state_q == EMIT;
  assign out_fire  = out_valid && out_ready;
  // Ready may follow out_ready: the FIFO side is registered.
  assign in_ready  = !flush &&
                     (!out_valid || (out_fire && last));
  assign in_fire   = in_valid && in_ready;
  assign load      = in_fire && legal;

  assign out_uop     = uops_q[idx_q];
  assign out_idx     = idx_q;
  assign out_first   = idx_q == '0;
  assign out_last    = out_valid && last;
  assign out_pc      = pc_q;
  assign err_illegal = err_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (1'b1)
      flush: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      !flush && load: begin
        state_d = EMIT;
        idx_d   = '0;
      end
      !flush && !load && out_fire && last: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      !flush && out_fire && !last: begin
        idx_d = idx_q + IDX_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      uops_q  <= '0;
      pc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= in_fire && !legal;
      if (flush) begin
        cnt_q  <= '0;
        uops_q <= '0;
        pc_q   <= '0;
      end else if (load) begin
        cnt_q  <= in_count;
        uops_q <= in_uops;
        pc_q   <= in_pc;
      end
    end
  end

`ifdef EZ90_UOP_CRACKER_PERF_EN
  uop_cracker_perf u_perf (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .inc_macro   (load),
    .inc_uop     (out_fire),
    .perf_macros (perf_macros),
    .perf_uops   (perf_uops)
  );
`endif

endmodule

// File: tb/tb_uop_cracker.sv
// Randomized bench for uop_cracker with a queue-based model.
// Perf ports checked when EZ90_UOP_CRACKER_PERF_EN is defined.
module tb_uop_cracker;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_count;
  logic [127:0] in_uops;
  logic [15:0]  in_pc;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_uop;
  logic [1:0]   out_idx;
  logic         out_first;
  logic         out_last;
  logic [15:0]  out_pc;
  logic         err_illegal;
`ifdef EZ90_UOP_CRACKER_PERF_EN
  logic [31:0]  perf_macros;
  logic [31:0]  perf_uops;
`endif

  uop_cracker dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_count    (in_count),
    .in_uops     (in_uops),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_uop     (out_uop),
    .out_idx     (out_idx),
    .out_first   (out_first),
    .out_last    (out_last),
    .out_pc      (out_pc),
`ifdef EZ90_UOP_CRACKER_PERF_EN
    .perf_macros (perf_macros),
    .perf_uops   (perf_uops),
`endif
    .err_illegal (err_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] uop;
    int          idx;
    bit          first;
    bit          last;
    logic [15:0] pc;
  } exp_uop_t;

  exp_uop_t mq[$];
  bit       err_exp;
  int       pm;
  int       pu;
  int       checks;
  int       errors;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Model: queue of uops still owed downstream.
  always @(negedge clk) begin
    bit exp_rdy;
    bit fire_in;
    bit fire_out;
    bit ok_cnt;
    exp_uop_t e;
    if (!rst_n) begin
      mq.delete();
      err_exp = 1'b0;
      pm = 0;
      pu = 0;
    end else begin
      exp_rdy = !flush && (mq.size() == 0 ||
                (out_ready && mq.size() == 1));
      chk("in_ready", in_ready, exp_rdy);
      chk("out_valid", out_valid, mq.size() != 0);
      chk("err_illegal", err_illegal, err_exp);
      if (mq.size() != 0) begin
        chk("out_uop", out_uop, mq[0].uop);
        chk("out_idx", out_idx, mq[0].idx);
        chk("out_first", out_first, mq[0].first);
        chk("out_last", out_last, mq[0].last);
        chk("out_pc", out_pc, mq[0].pc);
      end
`ifdef EZ90_UOP_CRACKER_PERF_EN
      chk("perf_macros", perf_macros, pm);
      chk("perf_uops", perf_uops, pu);
`endif
      fire_in  = in_valid && exp_rdy;
      fire_out = mq.size() != 0 && out_ready;
      ok_cnt   = in_count >= 1 && in_count <= 4;
      if (fire_out) begin
        void'(mq.pop_front());
        pu++;
      end
      err_exp = fire_in && !ok_cnt;
      if (fire_in && ok_cnt) begin
        pm++;
        for (int i = 0; i < int'(in_count); i++) begin
          e.uop   = in_uops[i*32 +: 32];
          e.idx   = i;
          e.first = i == 0;
          e.last  = i == int'(in_count) - 1;
          e.pc    = in_pc;
          mq.push_back(e);
        end
      end
      if (flush) begin
        mq.delete();
        pm = 0;
        pu = 0;
      end
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [2:0] n,
                       input logic [15:0] pc);
    in_valid = 1'b1;
    in_count = n;
    in_uops  = {$urandom, $urandom,
                $urandom, $urandom};
    in_pc    = pc;
  endtask

  initial begin
    bit rdy_pat [4];
    int idx_pat [4];
    int r;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_count  = '0;
    in_uops   = '0;
    in_pc     = '0;
    out_ready = 1'b0;
    #1 rst_n  = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_first", out_first, 1);
    chk("rst_out_last", out_last, 0);
    chk("rst_err", err_illegal, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_uop", out_uop, 0);
    chk("rst_out_pc", out_pc, 0);
    repeat (2) cyc();
    rst_n = 1'b1;

    // single-uop macro
    cyc();
    offer(3'd1, 16'h1234);
    in_uops[31:0] = 32'hA5A5_0001;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_valid", out_valid, 1);
    chk("t1_uop", out_uop, 32'hA5A5_0001);
    chk("t1_idx", out_idx, 0);
    chk("t1_first", out_first, 1);
    chk("t1_last", out_last, 1);
    chk("t1_pc", out_pc, 16'h1234);
    chk("t1_in_ready", in_ready, 1);

    // three uops with backpressure 1,0,1,1
    cyc();
    offer(3'd3, 16'h2222);
    cyc();
    in_valid = 1'b0;
    rdy_pat = '{1'b1, 1'b0, 1'b1, 1'b1};
    idx_pat = '{0, 1, 1, 2};
    for (int k = 0; k < 4; k++) begin
      out_ready = rdy_pat[k];
      @(negedge clk);
      chk("t2_idx", out_idx, idx_pat[k]);
      chk("t2_last", out_last, k == 3);
      cyc();
    end
    out_ready = 1'b1;
    cyc();

    // back-to-back 2-uop macros
    offer(3'd2, 16'h3000);
    cyc();
    offer(3'd2, 16'h3100);
    cyc();
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t3_valid", out_valid, 1);
    chk("t3_first", out_first, 1);
    chk("t3_pc", out_pc, 16'h3100);
    repeat (3) cyc();

    // illegal counts 0 then 5
    offer(3'd0, 16'h4000);
    cyc();
    offer(3'd5, 16'h4100);
    @(negedge clk);
    chk("t4_err0", err_illegal, 1);
    chk("t4_valid0", out_valid, 0);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t4_err1", err_illegal, 1);
    cyc();
    @(negedge clk);
    chk("t4_err2", err_illegal, 0);
    cyc();

    // flush mid-emit
    offer(3'd4, 16'h5000);
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    @(negedge clk);
    chk("t5_valid", out_valid, 0);
    chk("t5_in_ready", in_ready, 1);
    cyc();
    offer(3'd2, 16'h5100);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_idx", out_idx, 0);
    chk("t5_valid2", out_valid, 1);
    repeat (2) cyc();

    // async reset at idx 2
    offer(3'd4, 16'h6000);
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    #1;
    chk("t6_idx", out_idx, 2);
    chk("t6_valid", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_valid_rst", out_valid, 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    #1;
    chk("t6_in_ready", in_ready, 1);
`ifdef EZ90_UOP_CRACKER_PERF_EN
    chk("t6_perf_m", perf_macros, 0);
    chk("t6_perf_u", perf_uops, 0);
`endif

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      cyc();
      r = $urandom_range(0, 9);
      offer(r < 8 ? 3'($urandom_range(1, 4))
                  : 3'($urandom_range(5, 8) & 7),
            16'($urandom));
      in_valid  = $urandom_range(0, 9) < 6;
      out_ready = $urandom_range(0, 3) != 0;
      flush     = $urandom_range(0, 39) == 0;
    end
    cyc();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (8) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
